// File: rtl/encoder_7to3.sv
// encoder_7to3 -- debounced 7-line priority-free key encoder with handshake.
//
// Seven active-low request lines are synchronised, checked for a single
// asserted line, debounced for DEBOUNCE cycles and then presented as a 3-bit
// binary code that is held until the consumer acknowledges it. A held key
// yields exactly one code; simultaneous presses are rejected with an err pulse.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   En         enable; gates acceptance of new requests (never drops a held code)
//   e0..e6     request lines, active-low, asynchronous to clk
//   ack        consumer acknowledge, honoured only while valid=1
//   b0,b1,b2   registered code of accepted line, b0 = MSB; 111 when valid=0
//   valid      registered; high while b0..b2 carry an unacknowledged code
//   err        registered single-cycle pulse on a rejected multi-line press
module encoder_7to3 #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic En,
    input  logic e0,
    input  logic e1,
    input  logic e2,
    input  logic e3,
    input  logic e4,
    input  logic e5,
    input  logic e6,
    input  logic ack,
    output logic b0,
    output logic b1,
    output logic b2,
    output logic valid,
    output logic err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HOLD,
        S_RELEASE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);
    localparam logic [2:0] NO_CODE  = 3'b111;

    logic [6:0] e_raw;
    logic [6:0] sync1;
    logic [6:0] sync2;

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [6:0] cap_vec, cap_vec_d;
    logic [2:0] cap_code, cap_code_d;
    logic [2:0] out_code, out_code_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    // Set after an err pulse; blocks further err and captures until every
    // line has been seen released, so one sustained chord reports once.
    logic       err_block, err_block_d;

    logic [6:0] low_vec;
    logic       all_high;
    logic [2:0] n_low;
    logic [2:0] line_code;
    logic       single_low;
    logic       multi_low;

    assign e_raw = {e6, e5, e4, e3, e2, e1, e0};

    // Line analysis on the synchronised vector (lines are active-low).
    always_comb begin
        low_vec   = ~sync2;
        all_high  = &sync2;
        n_low     = '0;
        line_code = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            n_low = n_low + {2'b00, low_vec[i]};
            if (low_vec[i]) begin
                line_code = 3'(i);
            end
        end
        single_low = (n_low == 3'd1);
        multi_low  = (n_low >= 3'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '1;
            sync2     <= '1;
            state     <= S_IDLE;
            cnt       <= '0;
            cap_vec   <= '1;
            cap_code  <= NO_CODE;
            out_code  <= NO_CODE;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_block <= 1'b0;
        end else begin
            sync1     <= e_raw;
            sync2     <= sync1;
            state     <= state_d;
            cnt       <= cnt_d;
            cap_vec   <= cap_vec_d;
            cap_code  <= cap_code_d;
            out_code  <= out_code_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            err_block <= err_block_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        cap_vec_d   = cap_vec;
        cap_code_d  = cap_code;
        out_code_d  = out_code;
        valid_d     = valid_q;
        err_d       = 1'b0;
        err_block_d = err_block;

        if (all_high) begin
            err_block_d = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (En && !err_block) begin
                    if (single_low) begin
                        cap_vec_d  = sync2;
                        cap_code_d = line_code;
                        cnt_d      = '0;
                        state_d    = S_DEBOUNCE;
                    end else if (multi_low) begin
                        err_d       = 1'b1;
                        err_block_d = 1'b1;
                    end
                end
            end

            S_DEBOUNCE: begin
                if (En && (sync2 == cap_vec)) begin
                    if (cnt == CNT_LAST) begin
                        valid_d    = 1'b1;
                        out_code_d = cap_code;
                        state_d    = S_HOLD;
                    end else begin
                        cnt_d = cnt + 8'd1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end

            S_HOLD: begin
                if (ack) begin
                    valid_d    = 1'b0;
                    out_code_d = NO_CODE;
                    state_d    = S_RELEASE;
                end
            end

            S_RELEASE: begin
                if (all_high) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d    = S_IDLE;
                valid_d    = 1'b0;
                out_code_d = NO_CODE;
            end
        endcase
    end

    assign b0    = out_code[2];
    assign b1    = out_code[1];
    assign b2    = out_code[0];
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: doc/encoder_7to3.md
ENCODER_7TO3 -- requirements
Module: encoder_7to3

Interface
REQ-001 Parameter DEBOUNCE, default 4, number of consecutive synchronized cycles a single line must stay asserted before it is accepted; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 En  input  1  enable, active-high; gates acceptance of new requests.
REQ-005 e0..e6  input  1 each  request lines, active-low; asynchronous to clk.
REQ-006 ack  input  1  consumer acknowledge, active-high, sampled only while valid=1.
REQ-007 b0, b1, b2  output  1 each  registered code of the accepted line; b0 is the MSB and b2 the LSB.
REQ-008 valid  output  1  registered; high while b0..b2 hold an accepted, unacknowledged code.
REQ-009 err  output  1  registered single-cycle pulse flagging a rejected multi-line request.

Function
REQ-010 Each e line SHALL pass through a two-flop synchronizer before use; synchronizer flops reset to 1, the inactive level.
REQ-011 Code mapping SHALL be line index in binary, {b0,b1,b2}: e0=000, e1=001, e2=010, e3=011, e4=100, e5=101, e6=110.
REQ-012 Code 111 SHALL mean "no code" and SHALL be driven on b0..b2 whenever valid=0.
REQ-013 FSM states SHALL be IDLE, DEBOUNCE, HOLD and RELEASE, with an 8-bit debounce counter cnt.
REQ-014 IDLE, En=1, exactly one synchronized line low: capture its code and the 7-bit vector, set cnt=0, go to DEBOUNCE.
REQ-015 IDLE, En=1, two or more synchronized lines low: pulse err for one cycle, stay in IDLE, capture nothing; err SHALL NOT re-pulse until all lines are high for at least one cycle.
REQ-016 IDLE, En=0 or all lines high: remain in IDLE.
REQ-017 DEBOUNCE, vector equals the captured vector and En=1: if cnt=DEBOUNCE-1, go to HOLD and set valid=1 with b0..b2=code; otherwise increment cnt.
REQ-018 DEBOUNCE, vector differs from the captured vector or En=0: return to IDLE with valid=0 and no err.
REQ-019 Latency: counting the first clk edge that samples the line low as edge 1, valid SHALL first be high after edge 3+DEBOUNCE (edge 7 for DEBOUNCE=4).
REQ-020 HOLD: valid and b0..b2 SHALL stay stable regardless of En or the e lines until ack=1 is sampled.
REQ-021 HOLD, ack=1 sampled: on that edge clear valid, drive b0..b2=111, go to RELEASE.
REQ-022 RELEASE: remain until all synchronized lines are high for one cycle, then go to IDLE, so a held key yields exactly one code.
REQ-023 ack while valid=0 SHALL be ignored.
REQ-024 En deassertion SHALL never drop a code already in HOLD.

Reset
REQ-025 rst=1 at a clk edge SHALL force state IDLE, cnt=0, valid=0, err=0, b0..b2=111 and synchronizers all-ones, overriding every other input in any state.
REQ-026 A request in progress when reset is applied SHALL be discarded; after rst drops, the line must be seen again from IDLE with full synchronizer and debounce latency.

Verification
REQ-027 DEBOUNCE=4, En=1, hold e5=0 and others 1 -> valid rises after edge 7, b0..b2=101; ack on edge 10 -> valid=0 and b=111 after edge 10; no second valid while e5 stays low; after release and re-press -> a new code is issued.
REQ-028 e3=0 for only 3 synchronized cycles, then 1 -> no valid, no err, FSM back in IDLE.
REQ-029 e1 and e4 low together, En=1 -> one err pulse; no valid; no further err while both stay low; err pulses again after both release and re-press.
REQ-030 En=0 with e0=0 -> no valid; raising En while e0 is still low -> valid after DEBOUNCE+1 further edges with b=000.
REQ-031 In HOLD with b=110 (e6): drop En, toggle the e lines, keep ack=0 for 20 cycles -> valid and b stay 1/110 throughout.
REQ-032 Assert rst during DEBOUNCE and again during HOLD -> the next edge gives valid=0, err=0, b=111; after rst drops, a held line reappears only after 3+DEBOUNCE edges.
